// File: rtl/residual_add_requant.sv
// Residual add + requantize stage: joins the int32 matmul accumulator stream with the
// int8 residual stream, rescales each by its own (m, e), adds, and saturates to int8.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | accepting joined acc/res beats until N have been taken
// DRAIN | all inputs taken, flushing pipeline until N outputs handed off
// DONE  | tile complete, done high, waiting for next start
module residual_add_requant #(
  parameter int ROWS = 32,
  parameter int COLS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       requant_m_acc,
  input  logic [7:0]        requant_e_acc,
  input  logic [31:0]       requant_m_res,
  input  logic [7:0]        requant_e_res,
  input  logic [31:0]       acc_data,
  input  logic              acc_valid,
  input  logic              acc_last,
  output logic              acc_ready,
  input  logic [7:0]        res_data,
  input  logic              res_valid,
  output logic              res_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              done,
  output logic              error
);

  localparam logic [31:0] N = 32'(ROWS * COLS);
  localparam logic signed [64:0] SAT_HI = 65'sd127;
  localparam logic signed [64:0] SAT_LO = -65'sd128;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] in_cnt, out_cnt;
  logic [31:0] m_acc, m_res;
  logic [5:0]  e_acc, e_res;
  logic        en, join_fire, out_fire, start_ok, in_room;

  logic               v1, v2, v3;
  logic signed [31:0] a1;
  logic signed [7:0]  r1;
  logic signed [63:0] pa2, pr2;
  logic signed [63:0] ra3, rr3;
  logic signed [64:0] sum4;
  logic [7:0]         sat4;

  function automatic logic [5:0] clamp_e(input logic [7:0] e);
    return (e > 8'd62) ? 6'd62 : e[5:0];
  endfunction

  // 65-bit intermediate so the rounding constant cannot overflow a large product.
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] p,
                                                     input logic [5:0] e);
    logic signed [64:0] pw, rnd, sh;
    pw  = {p[63], p};
    rnd = (e == 6'd0) ? 65'sd0 : (65'sd1 <<< (e - 6'd1));
    sh  = (pw + rnd) >>> e;
    return sh[63:0];
  endfunction

  assign en        = !out_valid || out_ready;
  assign in_room   = in_cnt < N;
  assign acc_ready = (state == RUN) && en && res_valid && in_room;
  assign res_ready = (state == RUN) && en && acc_valid && in_room;
  assign join_fire = acc_valid && acc_ready;
  assign out_fire  = out_valid && out_ready;
  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign done      = (state == DONE);
  // Outputs leave strictly in order, so the output count alone marks the tile end.
  assign out_last  = out_valid && (out_cnt == N - 32'd1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (join_fire && (in_cnt == N - 32'd1)) state_nxt = DRAIN;
      DRAIN:   if (out_fire && (out_cnt == N - 32'd1)) state_nxt = DONE;
      DONE:    if (start_ok) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      in_cnt  <= '0;
      out_cnt <= '0;
      error   <= 1'b0;
      m_acc   <= '0;
      m_res   <= '0;
      e_acc   <= '0;
      e_res   <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        m_acc   <= requant_m_acc;
        m_res   <= requant_m_res;
        e_acc   <= clamp_e(requant_e_acc);
        e_res   <= clamp_e(requant_e_res);
        in_cnt  <= '0;
        out_cnt <= '0;
        error   <= 1'b0;
      end else begin
        if (join_fire) begin
          in_cnt <= in_cnt + 32'd1;
          if (acc_last != (in_cnt == N - 32'd1)) error <= 1'b1;
        end
        if (out_fire) out_cnt <= out_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    sum4 = {ra3[63], ra3} + {rr3[63], rr3};
    if (sum4 > SAT_HI)      sat4 = 8'h7f;
    else if (sum4 < SAT_LO) sat4 = 8'h80;
    else                    sat4 = sum4[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      a1        <= '0;
      r1        <= '0;
      pa2       <= '0;
      pr2       <= '0;
      ra3       <= '0;
      rr3       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      v1        <= join_fire;
      a1        <= acc_data;
      r1        <= res_data;
      v2        <= v1;
      pa2       <= $signed({{32{a1[31]}}, a1}) * $signed({32'd0, m_acc});
      pr2       <= $signed({{56{r1[7]}}, r1}) * $signed({32'd0, m_res});
      v3        <= v2;
      ra3       <= round_shift(pa2, e_acc);
      rr3       <= round_shift(pr2, e_res);
      out_valid <= v3;
      out_data  <= v3 ? sat4 : 8'd0;
    end
  end

endmodule

// File: tb/tb_residual_add_requant.sv
// Directed bench for residual_add_requant on a small 2x8 tile: hand-computed vectors,
// stall stability, framing error, start-in-RUN and mid-tile reset.
module tb_residual_add_requant;

  localparam int ROWS = 2;
  localparam int COLS = 8;
  localparam int N    = ROWS * COLS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] requant_m_acc = '0;
  logic [7:0]  requant_e_acc = '0;
  logic [31:0] requant_m_res = '0;
  logic [7:0]  requant_e_res = '0;
  logic [31:0] acc_data = '0;
  logic        acc_valid = 1'b0;
  logic        acc_last = 1'b0;
  logic        acc_ready;
  logic [7:0]  res_data = '0;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready = 1'b0;
  logic        done;
  logic        error;

  int errors = 0;
  int checks = 0;
  int acc_v [N];
  int res_v [N];
  int exp_v [N];
  logic [31:0] m_acc_cfg;

  residual_add_requant #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst(rst), .start(start),
    .requant_m_acc(requant_m_acc), .requant_e_acc(requant_e_acc),
    .requant_m_res(requant_m_res), .requant_e_res(requant_e_res),
    .acc_data(acc_data), .acc_valid(acc_valid), .acc_last(acc_last), .acc_ready(acc_ready),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [31:0] ma, input logic [7:0] ea,
                         input logic [31:0] mr, input logic [7:0] er);
    m_acc_cfg     = ma;
    requant_m_acc = ma;
    requant_e_acc = ea;
    requant_m_res = mr;
    requant_e_res = er;
  endtask

  task automatic clear_vec();
    for (int i = 0; i < N; i++) begin
      acc_v[i] = 0; res_v[i] = 0; exp_v[i] = 0;
    end
  endtask

  task automatic put(input int i, input int a, input int r, input int e);
    acc_v[i] = a; res_v[i] = r; exp_v[i] = e;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2;
    chk("done_fall", done, 0);
    chk("err_clr", error, 0);
  endtask

  // bad_at >= 0 puts acc_last on that beat only; start_at >= 0 pulses start mid-RUN.
  task automatic run_tile(input string name, input bit rnd_rdy, input bit rnd_gap,
                          input int bad_at, input int start_at, input bit exp_err,
                          input bit chk_lat);
    int nin = 0, nout = 0, cyc = 0, j0 = -1, o0 = -1;
    bit hold = 1'b0, sfired = 1'b0;
    logic [7:0] hd;
    logic hl;
    do_start();
    while (nout < N && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (nin < N) begin
        acc_valid = rnd_gap ? ($urandom_range(0, 3) != 0) : 1'b1;
        res_valid = rnd_gap ? ($urandom_range(0, 3) != 0) : 1'b1;
        acc_data  = acc_v[nin];
        res_data  = 8'(res_v[nin]);
        acc_last  = (bad_at >= 0) ? (nin == bad_at) : (nin == N - 1);
      end else begin
        acc_valid = 1'b0; res_valid = 1'b0; acc_last = 1'b0;
      end
      start = (start_at >= 0) && (nin == start_at) && !sfired;
      if (start) sfired = 1'b1;
      requant_m_acc = start ? 32'd7 : m_acc_cfg;
      #2;
      if (hold) begin
        chk({name, "_stall_data"}, out_data, hd);
        chk({name, "_stall_last"}, out_last, hl);
      end
      hold = out_valid && !out_ready;
      hd = out_data;
      hl = out_last;
      chk({name, "_join_pair"}, acc_valid && acc_ready, res_valid && res_ready);
      if (acc_valid && acc_ready) begin
        if (nin == 0) j0 = cyc;
        nin++;
      end
      if (out_valid && out_ready) begin
        chk({name, "_data"}, $signed(out_data), exp_v[nout]);
        chk({name, "_last"}, out_last, nout == N - 1);
        if (nout == N - 1) chk({name, "_done_early"}, done, 0);
        if (nout == 0) o0 = cyc;
        nout++;
      end
    end
    @(negedge clk);
    start = 1'b0; acc_valid = 1'b0; res_valid = 1'b0; acc_last = 1'b0;
    requant_m_acc = m_acc_cfg;
    #2;
    chk({name, "_outs"}, nout, N);
    chk({name, "_done"}, done, 1);
    chk({name, "_error"}, error, exp_err);
    chk({name, "_idle_ready"}, acc_ready, 0);
    if (chk_lat) chk({name, "_latency"}, o0 - j0, 4);
  endtask

  task automatic ramp_vec();
    // acc (e=1) rounds exactly to 9i-69, res contributes 8i-60; sum 17i-129 clipped.
    for (int i = 0; i < N; i++) begin
      acc_v[i] = 2 * (9 * i - 70) + 1;
      res_v[i] = 8 * i - 60;
      exp_v[i] = (17 * i - 129 < -128) ? -128 : (17 * i - 129 > 127 ? 127 : 17 * i - 129);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #2;
    chk("rst_acc_ready", acc_ready, 0);
    chk("rst_res_ready", res_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic, rounding half toward +inf, saturation: m_acc=1 e_acc=2, m_res=2 e_res=1
    set_cfg(32'd1, 8'd2, 32'd2, 8'd1);
    clear_vec();
    put(0, 100, -5, 20);
    put(1, 6, 0, 2);
    put(2, -6, 0, -1);
    put(3, 2, 0, 1);
    put(4, -2, 0, 0);
    put(5, 0, 1, 1);
    put(6, 0, -1, -1);
    put(7, 1000, 10, 127);
    put(8, -1000, -10, -128);
    run_tile("basic", 1'b0, 1'b0, -1, -1, 1'b0, 1'b1);

    // Zero shift, zero residual multiplier
    set_cfg(32'd1, 8'd0, 32'd0, 8'd0);
    clear_vec();
    put(0, 7, 0, 7);
    put(1, 7, 100, 7);
    put(2, -7, -3, -7);
    put(3, 127, 0, 127);
    put(4, 128, 0, 127);
    put(5, -129, 0, -128);
    run_tile("e0", 1'b0, 1'b0, -1, -1, 1'b0, 1'b0);

    // Saturation set: m_acc=3 e_acc=2, m_res=1 e_res=0
    set_cfg(32'd3, 8'd2, 32'd1, 8'd0);
    clear_vec();
    put(0, 1000, 10, 127);
    put(1, -1000, 10, -128);
    put(2, 10, 0, 8);
    put(3, -10, -1, -8);
    put(4, 0, -128, -128);
    put(5, 0, 127, 127);
    run_tile("sat", 1'b1, 1'b0, -1, -1, 1'b0, 1'b0);

    // Shift above 62 clamps to 62; extreme product exercises the wide rounding add
    set_cfg(32'hffff_ffff, 8'd70, 32'd1, 8'd63);
    clear_vec();
    put(0, 2147483647, 100, 2);
    put(1, int'(32'h8000_0000), -100, -2);
    run_tile("eclamp", 1'b0, 1'b0, -1, -1, 1'b0, 1'b0);

    set_cfg(32'd1, 8'd1, 32'd1, 8'd0);
    ramp_vec();
    run_tile("full", 1'b1, 1'b1, -1, -1, 1'b0, 1'b0);
    run_tile("frame", 1'b1, 1'b0, 5, -1, 1'b1, 1'b0);
    run_tile("restart", 1'b1, 1'b1, -1, 6, 1'b0, 1'b0);

    // Mid-tile reset: set error, stall a full pipeline, then reset
    do_start();
    @(negedge clk);
    acc_valid = 1'b1; res_valid = 1'b1; acc_last = 1'b1;
    acc_data = 32'd5; res_data = 8'd1; out_ready = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    chk("pre_rst_error", error, 1);
    chk("pre_rst_valid", out_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #2;
    chk("mid_rst_acc_ready", acc_ready, 0);
    chk("mid_rst_res_ready", res_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_error", error, 0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #2;
      chk("post_rst_quiet", out_valid || acc_ready, 0);
    end
    acc_valid = 1'b0; res_valid = 1'b0; acc_last = 1'b0;
    run_tile("clean", 1'b1, 1'b1, -1, -1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/residual_add_requant.md
# residual_add_requant

Streaming stage directly downstream of the intermediate (MM + GELU) stage, inside the BERT output stage. It joins the int32 accumulator stream of the output matmul (G~ · W_out) with the int8 residual stream. It requantizes each operand with its own fixed-point (multiplier, shift) pair, adds the results, and saturates to int8. It counts one ROWS×COLS tile per start and reports done/error to the stage controller.

## Interface
Parameters:
- ROWS, 32, rows per tile (INPUT_SIZE)
- COLS, 64, columns per tile (HIDDEN_SIZE)

Ports:
- clk  in  1  stage clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; accepted only in IDLE or DONE
- requant_m_acc  in  32  unsigned multiplier for accumulator (latched at start)
- requant_e_acc  in  8  right shift for accumulator, 0..62 (latched at start)
- requant_m_res  in  32  unsigned multiplier for residual (latched at start)
- requant_e_res  in  8  right shift for residual, 0..62 (latched at start)
- acc_data  in  32  signed accumulator
- acc_valid  in  1  acc beat valid
- acc_last  in  1  marks final acc beat of tile
- acc_ready  out  1  acc beat accepted when acc_valid && acc_ready
- res_data  in  8  signed residual
- res_valid  in  1  residual beat valid
- res_ready  out  1  residual handshake
- out_data  out  8  signed result
- out_valid  out  1  result valid
- out_last  out  1  final result of tile
- out_ready  in  1  downstream ready
- done  out  1  level, high in DONE state
- error  out  1  sticky framing error, cleared by start or rst

## Operation
- States: IDLE → (start) RUN → (in_cnt reaches N=ROWS·COLS) DRAIN → (out_cnt reaches N) DONE → (start) RUN.
- On start: latch the four requant fields, clear in_cnt, out_cnt and error.
- start in RUN or DRAIN is ignored.
- Join: en = !out_valid || out_ready.
  - acc_ready = (state==RUN) && en && res_valid && in_cnt<N.
  - res_ready = (state==RUN) && en && acc_valid && in_cnt<N.
  - Both streams transfer together, or neither does. A single-stream transfer is illegal.
- Framing: error is set when acc_last=1 on a join with in_cnt≠N−1, or acc_last=0 on the join with in_cnt=N−1. Processing continues; the count alone decides end of tile.
- Arithmetic, per operand x with (m,e):
  - p = sext64(x) · zext64(m)
  - r = (p + (e>0 ? 2^(e−1) : 0)) >>> e (arithmetic shift)
  - This rounds half toward +∞.
  - sum = r_acc + r_res in 65 bits, then saturated to [−128, 127].
  - e ≥ 63 is clamped to 62.
- out_last = 1 on the result with out_cnt = N−1.
- in_cnt and out_cnt are 32-bit. out_cnt increments on out_valid && out_ready.

## Timing
- 4-stage pipeline:
  - S1: join register
  - S2: both 32×32 multiplies
  - S3: round and shift
  - S4: add, saturate, output register
- Latency: join handshake in cycle t gives out_valid in cycle t+4 when unstalled.
- Throughput: one result per cycle.
- Stall: the whole pipeline advances only when en=1. Stage valids, data and out_data are held while out_valid && !out_ready. No bubble is inserted on release.
- out_data and out_last must stay stable while out_valid && !out_ready.
- Reset values: acc_ready=0, res_ready=0, out_valid=0, out_last=0, out_data=0, done=0, error=0, state=IDLE. Counters and all stage valids are cleared.
- rst mid-tile discards in-flight data. No output appears until the next start.
- done rises the cycle after the handshake of the N-th output. It falls the cycle after an accepted start.
- start coinciding with a handshake in DONE: the new tile's first join may occur the cycle after start.

## Test plan
- Basic: m_acc=1, e_acc=2, acc=100; m_res=2, e_res=1, res=−5 → out=20, latency 4 cycles.
- Rounding:
  - acc=6, m=1, e=2, res=0, m_res=0 → 2
  - acc=−6 → −1
  - e_acc=0, acc=7 → 7
- Saturation: acc=1000, m=3, e=2, res=10, m_res=1, e_res=0 → 127; acc=−1000 with the same settings → −128.
- Full tile with random out_ready (50%) and random acc/res valid gaps:
  - N outputs matching a golden model, in order
  - out_last only on the N-th output
  - done asserts after it, error=0
  - data is stable under stall
- Framing:
  - acc_last at beat 5 of N → error=1, N outputs still produced, done=1
  - next start clears error
- Control: start during RUN is ignored (count unchanged). rst asserted mid-tile → all outputs 0 next cycle. A following start runs a clean tile.
